// File: rtl/sparse_index_sequencer_pkg.sv
// Shared constants, state type and LFSR step for the sparse index sequencer.
// Optional real-slot rotation is selected with SEQ_ROTATE_EN (see top).
package seq_pkg;
  localparam int IDX_W     = 16;
  localparam int NUM_IDX   = 8;
  localparam int DUMMY_MAX = 8;
  localparam int KEY_W     = NUM_IDX * IDX_W;
  localparam int PTR_W     = 3;
  localparam int CNT_W     = 4;
  localparam int SEED_W    = 16;
  localparam logic [SEED_W-1:0] LFSR_POLY     = 16'hB400;
  localparam logic [SEED_W-1:0] LFSR_ZERO_SUB = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } seq_state_e;

  // Right-shifting Galois step: feedback mask applied when the bit shifted out is 1.
  function automatic logic [SEED_W-1:0] lfsr_step(input logic [SEED_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : '0);
  endfunction

  function automatic logic [CNT_W-1:0] clamp_dummy(input logic [CNT_W-1:0] req);
    return (req > CNT_W'(DUMMY_MAX)) ? CNT_W'(DUMMY_MAX) : req;
  endfunction
endpackage

// File: rtl/sparse_index_sequencer_if.sv
// Load/stream bus between the sequencer (slave) and its driver/consumer (master).
interface sparse_index_sequencer_if;
  import seq_pkg::*;

  logic                 load_i;
  logic [KEY_W-1:0]     key_i;
  logic [SEED_W-1:0]    seed_i;
  logic [CNT_W-1:0]     dummy_cnt_i;
  logic [IDX_W-1:0]     idx_o;
  logic                 dummy_o;
  logic                 valid_o;
  logic                 ready_i;
  logic                 last_o;
  logic                 busy_o;

  modport slave (
    input  load_i, key_i, seed_i, dummy_cnt_i, ready_i,
    output idx_o, dummy_o, valid_o, last_o, busy_o
  );

  modport master (
    output load_i, key_i, seed_i, dummy_cnt_i, ready_i,
    input  idx_o, dummy_o, valid_o, last_o, busy_o
  );
endinterface

// File: rtl/sparse_index_sequencer_lfsr.sv
// 16-bit Galois LFSR with seed load (zero seed substituted) and step enable.
// next_o exposes the stepped value so the caller can look one beat ahead.
module seq_lfsr16
  import seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [SEED_W-1:0] seed_i,
  output logic [SEED_W-1:0] state_o,
  output logic [SEED_W-1:0] next_o
);
  logic [SEED_W-1:0] state_q, state_d;

  assign next_o  = lfsr_step(state_q);
  assign state_o = state_q;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = (seed_i == '0) ? LFSR_ZERO_SUB : seed_i;
    end else if (step_i) begin
      state_d = next_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= '0;
    else     state_q <= state_d;
  end
endmodule

// File: rtl/sparse_index_sequencer.sv
// Streams the 8 key slots interleaved with LFSR dummy indices, one per handshake.
// Define SEQ_ROTATE_EN to start the real slots at the seed-derived lfsr[2:0].
//
// state | meaning
// IDLE  | waiting for load_i; key, seed and clamped dummy count latched on it
// LOAD  | one cycle; first beat computed from the fresh LFSR state
// EMIT  | beat presented; next beat computed on each handshake
module sparse_index_sequencer
  import seq_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  sparse_index_sequencer_if.slave  bus
);
  seq_state_e                          state_q;
  logic [NUM_IDX-1:0][IDX_W-1:0]       key_q;
  logic [CNT_W-1:0]                    r_left_q, d_left_q;
  logic [PTR_W-1:0]                    ptr_q;
  logic [IDX_W-1:0]                    idx_q;
  logic                                dummy_q, valid_q, last_q, busy_q;

  logic [SEED_W-1:0]                   lfsr_state, lfsr_next;
  logic                                lfsr_load, lfsr_step_en, hs;
  logic [PTR_W-1:0]                    start_ptr;

  logic [SEED_W-1:0]                   sel_lfsr;
  logic [CNT_W-1:0]                    sel_r, sel_d;
  logic [PTR_W-1:0]                    sel_ptr, nxt_ptr;
  logic [CNT_W:0]                      nxt_remain;
  logic                                nxt_dummy, nxt_last;
  logic [IDX_W-1:0]                    nxt_idx;

  assign hs           = (state_q == EMIT) && valid_q && bus.ready_i;
  assign lfsr_load    = (state_q == IDLE) && bus.load_i;
  assign lfsr_step_en = hs;

  seq_lfsr16 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (lfsr_load),
    .step_i  (lfsr_step_en),
    .seed_i  (bus.seed_i),
    .state_o (lfsr_state),
    .next_o  (lfsr_next)
  );

`ifdef SEQ_ROTATE_EN
  assign start_ptr = lfsr_state[PTR_W-1:0];
`else
  assign start_ptr = ptr_q;
`endif

  // Counters hold the totals including the presented beat; a handshake retires it.
  always_comb begin
    sel_lfsr   = lfsr_next;
    sel_r      = r_left_q - {{(CNT_W-1){1'b0}}, ~dummy_q};
    sel_d      = d_left_q - {{(CNT_W-1){1'b0}}, dummy_q};
    sel_ptr    = ptr_q;
    if (state_q == LOAD) begin
      sel_lfsr = lfsr_state;
      sel_r    = r_left_q;
      sel_d    = d_left_q;
      sel_ptr  = start_ptr;
    end
    nxt_dummy  = (sel_r == '0) || ((sel_d != '0) && sel_lfsr[0]);
    nxt_idx    = nxt_dummy ? sel_lfsr[IDX_W-1:0] : key_q[sel_ptr];
    nxt_ptr    = nxt_dummy ? sel_ptr : sel_ptr + PTR_W'(1);
    nxt_remain = {1'b0, sel_r} + {1'b0, sel_d};
    nxt_last   = (nxt_remain == (CNT_W+1)'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      key_q    <= '0;
      r_left_q <= '0;
      d_left_q <= '0;
      ptr_q    <= '0;
      idx_q    <= '0;
      dummy_q  <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.load_i) begin
            key_q    <= bus.key_i;
            r_left_q <= CNT_W'(NUM_IDX);
            d_left_q <= clamp_dummy(bus.dummy_cnt_i);
            ptr_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          idx_q   <= nxt_idx;
          dummy_q <= nxt_dummy;
          last_q  <= nxt_last;
          ptr_q   <= nxt_ptr;
          valid_q <= 1'b1;
          state_q <= EMIT;
        end
        EMIT: begin
          if (hs) begin
            r_left_q <= sel_r;
            d_left_q <= sel_d;
            if (nxt_remain == '0) begin
              idx_q   <= '0;
              dummy_q <= 1'b0;
              last_q  <= 1'b0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              idx_q   <= nxt_idx;
              dummy_q <= nxt_dummy;
              last_q  <= nxt_last;
              ptr_q   <= nxt_ptr;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.idx_o   = idx_q;
  assign bus.dummy_o = dummy_q;
  assign bus.valid_o = valid_q;
  assign bus.last_o  = last_q;
  assign bus.busy_o  = busy_q;
endmodule

// File: tb/tb_sparse_index_sequencer.sv
// Directed + randomized bench for sparse_index_sequencer against a beat-list reference model.
module tb_sparse_index_sequencer;
  import seq_pkg::*;

  typedef struct {
    logic [15:0] idx;
    logic        dummy;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  beat_t       exp_q[$];
  logic [15:0] obs_idx[$];
  logic        obs_dummy[$];
  logic [15:0] run1_idx[$];
  logic        run1_dummy[$];

  sparse_index_sequencer_if bus ();

  sparse_index_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the run beat by beat from the spec's selection rules.
  function automatic void build(input logic [127:0] key, input logic [15:0] seed, input logic [3:0] dcnt);
    logic [15:0] lf;
    int r, d, ptr, total;
    beat_t b;
    exp_q.delete();
    lf = (seed == 16'h0) ? 16'hACE1 : seed;
    r = 8;
    d = (dcnt > 8) ? 8 : int'(dcnt);
`ifdef SEQ_ROTATE_EN
    ptr = int'(lf) % 8;
`else
    ptr = 0;
`endif
    total = r + d;
    for (int n = 0; n < total; n++) begin
      b.dummy = (r == 0) || (d != 0 && lf[0]);
      if (b.dummy) begin
        b.idx = lf;
        d--;
      end else begin
        b.idx = key[16*ptr +: 16];
        ptr = (ptr + 1) % 8;
        r--;
      end
      b.last = (n == total - 1);
      exp_q.push_back(b);
      lf = (lf >> 1) ^ (lf[0] ? 16'hB400 : 16'h0);
    end
  endfunction

  task automatic run_stream(input logic [127:0] key, input logic [15:0] seed, input logic [3:0] dcnt,
                            input int stall_beat, input int stall_len, input bit rnd_ready,
                            input int inj_beat, input int abort_beat);
    int b = 0, cyc = 0, stall_cnt = 0;
    bit done = 0, have_held = 0, rdy;
    logic [15:0] h_idx;
    logic h_dummy, h_last;
    build(key, seed, dcnt);
    obs_idx.delete();
    obs_dummy.delete();
    @(negedge clk);
    bus.key_i = key; bus.seed_i = seed; bus.dummy_cnt_i = dcnt;
    bus.load_i = 1'b1; bus.ready_i = 1'b0;
    @(negedge clk);
    bus.load_i = 1'b0;
    chk("busy_after_load", bus.busy_o, 1);
    chk("valid_in_load", bus.valid_o, 0);
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      bus.load_i = 1'b0;
      chk("valid_in_run", bus.valid_o, 1);
      if (have_held) begin
        chk("stall_idx", bus.idx_o, h_idx);
        chk("stall_dummy", bus.dummy_o, h_dummy);
        chk("stall_last", bus.last_o, h_last);
        have_held = 0;
      end
      if (b == abort_beat) begin
        rst = 1'b1; bus.ready_i = 1'b0;
        @(negedge clk);
        chk("abort_valid", bus.valid_o, 0);
        chk("abort_busy", bus.busy_o, 0);
        rst = 1'b0;
        return;
      end
      if (b == inj_beat) begin
        bus.load_i = 1'b1;
        bus.key_i = ~key;
        bus.dummy_cnt_i = 4'd7;
      end
      if (b == stall_beat && stall_cnt < stall_len) begin
        rdy = 0; stall_cnt++;
      end else if (rnd_ready) rdy = ($urandom_range(0, 2) != 0);
      else rdy = 1;
      bus.ready_i = rdy;
      if (rdy) begin
        chk("beat_idx", bus.idx_o, exp_q[b].idx);
        chk("beat_dummy", bus.dummy_o, exp_q[b].dummy);
        chk("beat_last", bus.last_o, exp_q[b].last);
        obs_idx.push_back(bus.idx_o);
        obs_dummy.push_back(bus.dummy_o);
        b++;
        if (b == exp_q.size()) begin
          @(negedge clk);
          bus.ready_i = 1'b0;
          bus.load_i = 1'b0;
          chk("end_valid", bus.valid_o, 0);
          chk("end_busy", bus.busy_o, 0);
          done = 1;
        end
      end else begin
        h_idx = bus.idx_o; h_dummy = bus.dummy_o; h_last = bus.last_o;
        have_held = 1;
      end
    end
    bus.load_i = 1'b0;
    chk("stream_completed", done, 1);
  endtask

  // Independent of the model: counts, real-slot order, non-zero dummy indices.
  task automatic post_checks(input logic [127:0] key, input int exp_d);
    int nd = 0, start = 0, k = 0;
    logic [15:0] reals[$];
    chk("n_beats", obs_idx.size(), 8 + exp_d);
    for (int i = 0; i < obs_idx.size(); i++) begin
      if (obs_dummy[i]) begin
        nd++;
        chk("dummy_nonzero", (obs_idx[i] != 16'h0), 1);
      end else reals.push_back(obs_idx[i]);
    end
    chk("n_dummy", nd, exp_d);
`ifdef SEQ_ROTATE_EN
    for (int s = 0; s < 8; s++) if (reals.size() > 0 && key[16*s +: 16] == reals[0]) start = s;
`endif
    foreach (reals[i]) begin
      k = (start + i) % 8;
      chk("real_order", reals[i], key[16*k +: 16]);
    end
  endtask

  initial begin : main
    logic [127:0] key_a, key_r;
    logic [15:0] seed_r;
    logic [3:0] dcnt_r;
    key_a = 128'h8888_7777_6666_5555_4444_3333_2222_1111;
    bus.load_i = 0; bus.key_i = '0; bus.seed_i = '0; bus.dummy_cnt_i = '0; bus.ready_i = 0;

    repeat (2) @(negedge clk);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_idx", bus.idx_o, 0);
    chk("rst_dummy", bus.dummy_o, 0);
    chk("rst_last", bus.last_o, 0);
    rst = 1'b0;

    // plain 8-beat run
    run_stream(key_a, 16'h1234, 4'd0, -1, 0, 0, -1, -1);
    post_checks(key_a, 0);

    // 4 dummies, repeated with the same seed under random backpressure
    run_stream(key_a, 16'h1234, 4'd4, -1, 0, 1, -1, -1);
    post_checks(key_a, 4);
    run1_idx = obs_idx; run1_dummy = obs_dummy;
    run_stream(key_a, 16'h1234, 4'd4, -1, 0, 1, -1, -1);
    chk("repeat_len", obs_idx.size(), run1_idx.size());
    foreach (run1_idx[i]) begin
      chk("repeat_idx", obs_idx[i], run1_idx[i]);
      chk("repeat_dummy", obs_dummy[i], run1_dummy[i]);
    end

    // stall 3 cycles on beat 5
    run_stream(key_a, 16'h5A5A, 4'd2, 4, 3, 0, -1, -1);
    post_checks(key_a, 2);

    // load during beat 3 must be ignored
    run_stream(key_a, 16'h0F0F, 4'd0, -1, 0, 0, 2, -1);
    post_checks(key_a, 0);

    // reset at beat 4, then a fresh full run
    run_stream(key_a, 16'hBEEF, 4'd3, -1, 0, 0, -1, 3);
    run_stream(key_a, 16'hBEEF, 4'd3, -1, 0, 0, -1, -1);
    post_checks(key_a, 3);

    // reset and load together: reset wins
    @(negedge clk);
    rst = 1'b1; bus.load_i = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.load_i = 1'b0;
    @(negedge clk);
    chk("rst_load_busy", bus.busy_o, 0);
    chk("rst_load_valid", bus.valid_o, 0);

    // clamp and zero-seed substitution
    run_stream(key_a, 16'h0000, 4'd15, -1, 0, 1, -1, -1);
    post_checks(key_a, 8);

    for (int t = 0; t < 6; t++) begin
      key_r = {$urandom, $urandom, $urandom, $urandom};
      seed_r = 16'($urandom);
      dcnt_r = 4'($urandom_range(0, 15));
      run_stream(key_r, seed_r, dcnt_r, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1, -1, -1);
      post_checks(key_r, (dcnt_r > 8) ? 8 : int'(dcnt_r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
